// File: rtl/ccu_pkg.sv
// Definitions shared by the CCU, the DPU and the line sequencer:
// DPU register map, opcodes and the sequencer state encoding.
package ccu_pkg;

    localparam logic [3:0] REG_DX     = 4'd0;
    localparam logic [3:0] REG_DY     = 4'd1;
    localparam logic [3:0] REG_ERR    = 4'd2;
    localparam logic [3:0] REG_EINC   = 4'd3;
    localparam logic [3:0] REG_ENOINC = 4'd4;
    localparam logic [3:0] REG_XS     = 4'd5;
    localparam logic [3:0] REG_XE     = 4'd6;
    localparam logic [3:0] REG_YS     = 4'd7;
    localparam logic [3:0] REG_YE     = 4'd8;
    localparam logic [3:0] REG_X      = 4'd9;
    localparam logic [3:0] REG_Y      = 4'd10;
    localparam logic [3:0] REG_COL    = 4'd11;
    localparam logic [3:0] REG_ONE    = 4'd12;
    localparam logic [3:0] REG_ZERO   = 4'd13;
    localparam logic [3:0] REG_SCR    = 4'd14;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SHL = 4'd2;
    localparam logic [3:0] OP_CMP = 4'd6;
    localparam logic [3:0] OP_LD  = 4'd8;
    localparam logic [3:0] OP_NOP = 4'd15;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD,
        S_SETUP,
        S_INIT,
        S_PLOT,
        S_TEST,
        S_CCWAIT,
        S_ERR_NEG,
        S_Y_INC,
        S_ERR_POS,
        S_INCX,
        S_DONE
    } seq_state_e;

    typedef struct packed {
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] r;
    } uop_t;

    function automatic uop_t mk_uop(
        input logic [3:0] op,
        input logic [3:0] a,
        input logic [3:0] b,
        input logic [3:0] r
    );
        uop_t u;
        u.op = op;
        u.a  = a;
        u.b  = b;
        u.r  = r;
        return u;
    endfunction

endpackage

// File: rtl/line_sequencer.sv
// First-octant Bresenham micro-op sequencer driving the DPU, one op per clock.
// Define LINE_SWAP_EN to swap endpoints at start so xe < xs lines draw fully.
module line_sequencer
    import ccu_pkg::*;
#(
    parameter int CC_LAT = 1,
    parameter int W      = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] xs,
    input  logic [W-1:0] ys,
    input  logic [W-1:0] xe,
    input  logic [W-1:0] ye,
    input  logic [W-1:0] colour,
    output logic         busy,
    output logic         done,
    output logic [3:0]   a_sel,
    output logic [3:0]   b_sel,
    output logic [3:0]   r_sel,
    output logic [3:0]   op,
    output logic [W-1:0] mdata,
    input  logic [3:0]   cc,
    output logic         out_en,
    output logic         pix_valid,
    input  logic         pix_ready
);

    localparam logic [3:0] CC_LAST = 4'(CC_LAT - 1);

    seq_state_e   state_q, state_d;
    logic [3:0]   step_q, step_d;
    logic [W-1:0] xs_q, xs_d;
    logic [W-1:0] ys_q, ys_d;
    logic [W-1:0] xe_q, xe_d;
    logic [W-1:0] ye_q, ye_d;
    logic [W-1:0] col_q, col_d;
    logic [W:0]   tx_q, tx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         pix_q, pix_d;
    uop_t         uop_q, uop_d;
    logic [W-1:0] mdata_q, mdata_d;

    logic         swap;
    logic         hs;
    logic         last_pix;
    logic [W:0]   tx_inc;
    logic         unused_cc;

    assign unused_cc = ^cc[2:0];
    assign hs        = pix_q & pix_ready;
    assign tx_inc    = tx_q + (W+1)'(1);
    assign last_pix  = tx_q >= {1'b0, xe_q};

`ifdef LINE_SWAP_EN
    assign swap = xe < xs;
`else
    assign swap = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        xs_d    = xs_q;
        ys_d    = ys_q;
        xe_d    = xe_q;
        ye_d    = ye_q;
        col_d   = col_q;
        tx_d    = tx_q;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    xs_d    = swap ? xe : xs;
                    ys_d    = swap ? ye : ys;
                    xe_d    = swap ? xs : xe;
                    ye_d    = swap ? ys : ye;
                    col_d   = colour;
                    step_d  = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (step_q == 4'd4) begin
                    step_d  = '0;
                    state_d = S_SETUP;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_SETUP: begin
                if (step_q == 4'd4) begin
                    step_d  = '0;
                    state_d = S_INIT;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_INIT: begin
                tx_d = {1'b0, xs_q};
                if (step_q == 4'd1) begin
                    step_d  = '0;
                    state_d = S_PLOT;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            // The last pixel exits straight after its handshake.
            S_PLOT: begin
                if (hs) begin
                    state_d = last_pix ? S_DONE : S_TEST;
                end
            end
            S_TEST: begin
                step_d  = '0;
                state_d = S_CCWAIT;
            end
            S_CCWAIT: begin
                if (step_q == CC_LAST) begin
                    step_d  = '0;
                    state_d = cc[3] ? S_ERR_NEG : S_Y_INC;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            S_ERR_NEG: state_d = S_INCX;
            S_Y_INC:   state_d = S_ERR_POS;
            S_ERR_POS: state_d = S_INCX;
            S_INCX: begin
                tx_d    = tx_inc;
                state_d = (tx_inc > {1'b0, xe_q}) ? S_DONE : S_PLOT;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it.
    always_comb begin
        uop_d   = mk_uop(OP_NOP, REG_DX, REG_DX, REG_DX);
        mdata_d = '0;
        busy_d  = 1'b1;
        done_d  = 1'b0;
        pix_d   = 1'b0;
        unique case (state_d)
            S_IDLE: busy_d = 1'b0;
            S_LOAD: begin
                uop_d.op = OP_LD;
                unique case (step_d)
                    4'd0: begin
                        mdata_d = xs_d;
                        uop_d.r = REG_XS;
                    end
                    4'd1: begin
                        mdata_d = ys_d;
                        uop_d.r = REG_YS;
                    end
                    4'd2: begin
                        mdata_d = xe_d;
                        uop_d.r = REG_XE;
                    end
                    4'd3: begin
                        mdata_d = ye_d;
                        uop_d.r = REG_YE;
                    end
                    default: begin
                        mdata_d = col_d;
                        uop_d.r = REG_COL;
                    end
                endcase
            end
            S_SETUP: begin
                unique case (step_d)
                    4'd0: uop_d = mk_uop(OP_SUB, REG_YE, REG_YS, REG_DY);
                    4'd1: uop_d = mk_uop(OP_SUB, REG_XE, REG_XS, REG_DX);
                    4'd2: uop_d = mk_uop(OP_SHL, REG_DY, REG_ZERO, REG_ENOINC);
                    4'd3: uop_d = mk_uop(OP_SUB, REG_ENOINC, REG_DX, REG_ERR);
                    default: uop_d = mk_uop(OP_SUB, REG_ERR, REG_DX, REG_EINC);
                endcase
            end
            S_INIT: begin
                uop_d.op = OP_LD;
                if (step_d == 4'd0) begin
                    mdata_d = xs_d;
                    uop_d.r = REG_X;
                end else begin
                    mdata_d = ys_d;
                    uop_d.r = REG_Y;
                end
            end
            S_PLOT:    pix_d = 1'b1;
            S_TEST:    uop_d = mk_uop(OP_CMP, REG_ERR, REG_ZERO, REG_SCR);
            S_ERR_NEG: uop_d = mk_uop(OP_ADD, REG_ERR, REG_ENOINC, REG_ERR);
            S_Y_INC:   uop_d = mk_uop(OP_ADD, REG_Y, REG_ONE, REG_Y);
            S_ERR_POS: uop_d = mk_uop(OP_ADD, REG_ERR, REG_EINC, REG_ERR);
            S_INCX:    uop_d = mk_uop(OP_ADD, REG_X, REG_ONE, REG_X);
            S_DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            step_q  <= '0;
            xs_q    <= '0;
            ys_q    <= '0;
            xe_q    <= '0;
            ye_q    <= '0;
            col_q   <= '0;
            tx_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pix_q   <= 1'b0;
            uop_q   <= '0;
            mdata_q <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            xs_q    <= xs_d;
            ys_q    <= ys_d;
            xe_q    <= xe_d;
            ye_q    <= ye_d;
            col_q   <= col_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            pix_q   <= pix_d;
            uop_q   <= uop_d;
            mdata_q <= mdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign op        = uop_q.op;
    assign a_sel     = uop_q.a;
    assign b_sel     = uop_q.b;
    assign r_sel     = uop_q.r;
    assign mdata     = mdata_q;
    assign out_en    = pix_q;
    assign pix_valid = pix_q;

endmodule

// File: tb/tb_line_sequencer.sv
// Bench for line_sequencer: a small DPU model executes the micro-ops and
// the plotted pixels are compared with a direct Bresenham reference.
module tb_line_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [W-1:0] xs, ys, xe, ye, colour;
    logic         busy, done;
    logic [3:0]   a_sel, b_sel, r_sel, op;
    logic [W-1:0] mdata;
    logic [3:0]   cc = 4'b0;
    logic         out_en, pix_valid;
    logic         pix_ready = 1'b0;

    line_sequencer #(.CC_LAT(1), .W(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .xs(xs), .ys(ys), .xe(xe), .ye(ye), .colour(colour),
        .busy(busy), .done(done),
        .a_sel(a_sel), .b_sel(b_sel), .r_sel(r_sel), .op(op),
        .mdata(mdata), .cc(cc),
        .out_en(out_en), .pix_valid(pix_valid), .pix_ready(pix_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t exp_q[$];
    pix_t got_q[$];
    int   vec_cnt = 0;
    int   err_cnt = 0;
    logic [W-1:0] rf [16] = '{default: '0};
    int   stall_req = 0;
    int   stall_cnt = 0;
    int   done_cnt  = 0;
    int   yinc_cnt  = 0;
    int   exp_n     = -1;
    bit   pending   = 0;
    bit   last_seen = 0;
    int   hold_x, hold_y;

    task automatic check(input string tag, input int got, input int expv);
        vec_cnt++;
        if (got != expv) begin
            err_cnt++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    function automatic logic [W-1:0] rd(input logic [3:0] i);
        if (i == 4'd12) return W'(1);
        if (i == 4'd13) return W'(0);
        return rf[i];
    endfunction

    function automatic logic [W-1:0] alu(input logic [3:0] o,
                                         input logic [W-1:0] a,
                                         input logic [W-1:0] b,
                                         input logic [W-1:0] m);
        case (o)
            4'd0:       return a + b;
            4'd1, 4'd6: return a - b;
            4'd2:       return a << 1;
            4'd8:       return m;
            default:    return a;
        endcase
    endfunction

    function automatic logic is_neg(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] d;
        d = a - b;
        return d[W-1];
    endfunction

    // DPU: registered result, cc valid the cycle after the compare
    always @(posedge clk) begin
        if (op != 4'd15 && r_sel != 4'd12 && r_sel != 4'd13)
            rf[r_sel] <= alu(op, rd(a_sel), rd(b_sel), mdata);
        if (op == 4'd6)
            cc <= {is_neg(rd(a_sel), rd(b_sel)), 3'b000};
    end

    always @(negedge clk) begin
        if (rst) begin
            pix_ready = 1'b0;
            pending   = 0;
            last_seen = 0;
            stall_cnt = 0;
        end else begin
            if (last_seen) begin
                check("done_after_last_hs", done, 1);
                last_seen = 0;
            end
            if (done) begin
                done_cnt++;
                check("busy_low_at_done", busy, 0);
            end
            if (op == 4'd0 && r_sel == 4'd10) yinc_cnt++;
            check("out_en_eq_valid", out_en, pix_valid);
            if (pending) check("valid_held", pix_valid, 1);
            if (pix_valid) begin
                check("nop_while_valid", op, 15);
                if (pending) begin
                    check("x_stable", rd(4'd9), hold_x);
                    check("y_stable", rd(4'd10), hold_y);
                end
                hold_x = rd(4'd9);
                hold_y = rd(4'd10);
                if (stall_cnt < stall_req) begin
                    stall_cnt++;
                    pix_ready = 1'b0;
                    pending   = 1;
                end else begin
                    pix_ready = 1'b1;
                    pending   = 0;
                    stall_cnt = 0;
                    got_q.push_back('{int'(rd(4'd9)), int'(rd(4'd10)), int'(rd(4'd11))});
                    if (got_q.size() == exp_n) last_seen = 1;
                end
            end else begin
                pix_ready = 1'b0;
                pending   = 0;
            end
        end
    end

    function automatic void model(input int x0, input int y0,
                                  input int x1, input int y1, input int c);
        int dx, dy, err, y, t;
        exp_q.delete();
`ifdef LINE_SWAP_EN
        if (x1 < x0) begin
            t = x0; x0 = x1; x1 = t;
            t = y0; y0 = y1; y1 = t;
        end
`endif
        if (x1 < x0) begin
            exp_q.push_back('{x0, y0, c});
            return;
        end
        dx  = x1 - x0;
        dy  = y1 - y0;
        err = 2 * dy - dx;
        y   = y0;
        for (int x = x0; x <= x1; x++) begin
            exp_q.push_back('{x, y, c});
            if (err < 0) begin
                err += 2 * dy;
            end else begin
                y++;
                err += 2 * (dy - dx);
            end
        end
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_out_en"}, out_en, 0);
        check({tag, "_pix_valid"}, pix_valid, 0);
        check({tag, "_op"}, op, 0);
        check({tag, "_sels"}, {a_sel, b_sel, r_sel}, 0);
        check({tag, "_mdata"}, mdata, 0);
    endtask

    task automatic run_line(input int x0, input int y0, input int x1, input int y1,
                            input int c, input int stalls, input bit geom, input bit poke);
        bit ok;
        int n;
        model(x0, y0, x1, y1, c);
        got_q.delete();
        done_cnt  = 0;
        yinc_cnt  = 0;
        stall_req = stalls;
        exp_n     = exp_q.size();
        @(negedge clk);
        xs = W'(x0); ys = W'(y0); xe = W'(x1); ye = W'(y1); colour = W'(c);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        if (poke) begin
            repeat (2) @(negedge clk);
            xs = 8'd99; ys = 8'd99; xe = 8'd1; ye = 8'd1; colour = 8'd1;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        ok = 0;
        for (int i = 0; i < 4000 && !ok; i++) begin
            @(negedge clk);
            if (done_cnt > 0) ok = 1;
        end
        check("terminated", ok, 1);
        repeat (3) @(negedge clk);
        check("done_once", done_cnt, 1);
        check("busy_idle", busy, 0);
        check("op_idle_nop", op, 15);
        check("pixel_count", got_q.size(), exp_n);
        if (geom) begin
            n = (got_q.size() < exp_n) ? got_q.size() : exp_n;
            for (int i = 0; i < n; i++) begin
                check($sformatf("pix%0d_x", i), got_q[i].x, exp_q[i].x);
                check($sformatf("pix%0d_y", i), got_q[i].y, exp_q[i].y);
                check($sformatf("pix%0d_c", i), got_q[i].c, exp_q[i].c);
            end
            check("y_inc_ops", yinc_cnt, exp_q[exp_n-1].y - exp_q[0].y);
        end
        if (!ok) begin
            rst = 1'b1;
            repeat (2) @(negedge clk);
            rst = 1'b0;
        end
    endtask

    initial begin
        int dx, dy, x0, y0;
        rst = 1'b1; start = 1'b0;
        xs = '0; ys = '0; xe = '0; ye = '0; colour = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        @(negedge clk);
        check("idle_op_nop", op, 15);
        check("idle_busy", busy, 0);

        run_line(0, 0, 4, 2, 7, 0, 1, 1);
        run_line(10, 5, 13, 5, 3, 0, 1, 0);
        run_line(3, 3, 3, 3, 5, 0, 1, 0);
        run_line(250, 0, 255, 0, 2, 0, 1, 0);
        run_line(0, 0, 4, 2, 7, 3, 1, 0);

        got_q.delete();
        exp_n = -1;
        @(negedge clk);
        xs = 8'd0; ys = 8'd0; xe = 8'd4; ye = 8'd2; colour = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("setup_op", op, 1);
        check("setup_rsel", r_sel, 1);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("mid_reset");
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_nop", op, 15);
        check("post_reset_no_pix", got_q.size(), 0);

        run_line(0, 0, 2, 2, 9, 0, 1, 0);
        run_line(4, 2, 0, 0, 7, 0, 1, 0);
        run_line(0, 0, 3, 9, 1, 0, 0, 0);
        run_line(5, 9, 8, 2, 1, 1, 0, 0);

        for (int k = 0; k < 8; k++) begin
            dx = $urandom_range(0, 40);
            dy = $urandom_range(0, dx);
            x0 = $urandom_range(0, 255 - dx);
            y0 = $urandom_range(0, 255 - dy);
            run_line(x0, y0, x0 + dx, y0 + dy, $urandom_range(0, 255),
                     $urandom_range(0, 3), 1, 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
